// File: rtl/fabric_pkg.sv
// Encodings and helpers shared by fabric initiators and targets.
// Size codes, error codes, target FSM states and the byte-lane enable helpers.
package fabric_pkg;

  localparam logic [1:0] FAB_SZ_B = 2'd0;
  localparam logic [1:0] FAB_SZ_H = 2'd1;
  localparam logic [1:0] FAB_SZ_W = 2'd2;

  localparam logic [1:0] FAB_ERR_OK    = 2'd0;
  localparam logic [1:0] FAB_ERR_ALIGN = 2'd1;
  localparam logic [1:0] FAB_ERR_RANGE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } fab_tgt_state_t;

  // Size code 3 is reserved and behaves as a word access.
  function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      FAB_SZ_B: be_from = 4'b0001 << addr_lo;
      FAB_SZ_H: be_from = 4'b0011 << addr_lo;
      default:  be_from = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      FAB_SZ_B: misaligned = 1'b0;
      FAB_SZ_H: misaligned = addr_lo[0];
      default:  misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/fabric_sram_array.sv
// Word-wide single-port storage: per-byte write enables, registered read port.
// No reset so it maps onto block RAM; the read register holds until the next read.
module fabric_sram_array #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic [IW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fabric_sram_target.sv
// Fabric SRAM responder: one outstanding request, response 1+WAIT_STATES cycles after acceptance.
// req_ready only in IDLE; the response is held stable for as long as resp_ready stays low.
module fabric_sram_target
  import fabric_pkg::*;
#(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam int         AW      = $clog2(MEM_BYTES);
  localparam int         IW      = (AW > 2) ? AW - 2 : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  fab_tgt_state_t r_state;
  fab_tgt_state_t w_state_nxt;
  logic [3:0]     r_cnt;
  logic [1:0]     r_err;
  logic           r_rd_ok;

  logic           w_accept;
  logic [1:0]     w_err;
  logic [3:0]     w_we;
  logic           w_re;
  logic [IW-1:0]  w_idx;
  logic [31:0]    w_rdata;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  always_comb begin
    w_err = FAB_ERR_OK;
    if (misaligned(req_size, req_addr[1:0])) w_err = FAB_ERR_ALIGN;
    else if (req_addr >= 32'(MEM_BYTES))    w_err = FAB_ERR_RANGE;
  end

  // Truncation is safe: any address that would alias has already failed the range check.
  assign w_idx = IW'(req_addr >> 2);
  assign w_we  = (w_accept && req_write && (w_err == FAB_ERR_OK)) ? be_from(req_size, req_addr[1:0]) : 4'h0;
  assign w_re  = w_accept && !req_write && (w_err == FAB_ERR_OK);

  fabric_sram_array #(
    .DEPTH (MEM_BYTES / 4),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .i_addr  (w_idx),
    .i_we    (w_we),
    .i_wdata (req_wdata),
    .i_re    (w_re),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= FAB_ERR_OK;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= WS_LOAD;
        r_err   <= w_err;
        r_rd_ok <= w_re;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // The array's read register is never reset; r_rd_ok masks it after reset, writes and errors.
  assign req_ready  = rst_n && (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rd_ok ? w_rdata : 32'h0;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_fabric_sram_target.sv
// Bench for fabric_sram_target: two instances (0 and 3 wait states) against a byte-array reference.
module tb_fabric_sram_target;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic [1:0][1:0]  req_size, resp_err;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;

  int errors = 0;
  int checks = 0;

  fabric_sram_target #(.MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  fabric_sram_target #(.MEM_BYTES(4096), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  logic [7:0] mm [2][4096];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: access size in bytes, first lane, then plain byte-array read/modify.
  task automatic model_apply(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] erd, output logic [1:0] eer);
    int nbytes, first, base;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    first  = (nbytes == 4) ? 0 : int'(a % 4);
    erd    = 32'h0;
    if ((a % nbytes) != 0)    eer = 2'd1;
    else if (a >= 32'd4096)   eer = 2'd2;
    else                      eer = 2'd0;
    if (eer == 2'd0) begin
      base = int'(a - (a % 4));
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (b >= first && b < first + nbytes) mm[d][base + b] = wd[8*b +: 8];
      end else begin
        erd = {mm[d][base + 3], mm[d][base + 2], mm[d][base + 1], mm[d][base]};
      end
    end
  endtask

  task automatic txn(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic [1:0] er, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid[d] && lat < 100) begin @(negedge clk); lat++; end
    rd = resp_rdata[d];
    er = resp_err[d];
    for (int i = 0; i < hold; i++) begin
      check("hold_req_ready", 32'(req_ready[d]), 32'd0);
      check("hold_valid", 32'(resp_valid[d]), 32'd1);
      check("hold_rdata", resp_rdata[d], rd);
      check("hold_err", 32'(resp_err[d]), 32'(er));
      @(negedge clk);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    @(negedge clk);
    check("valid_after_hs", 32'(resp_valid[d]), 32'd0);
    check("ready_after_hs", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic run(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic [1:0] er);
    logic [31:0] erd;
    logic [1:0]  eer;
    int          lat;
    model_apply(d, wr, sz, a, wd, erd, eer);
    txn(d, wr, sz, a, wd, hold, rd, er, lat);
    check("rdata", rd, erd);
    check("err", 32'(er), 32'(eer));
    check("latency", 32'(lat), 32'(1 + ws_of(d)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    logic [31:0] erd, a;
    logic [1:0]  eer;
    int          n, d;

    req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_req_ready", 32'(req_ready[k]), 32'd0);
      check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("rst_rdata", resp_rdata[k], 32'd0);
      check("rst_err", 32'(resp_err[k]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready0", 32'(req_ready[0]), 32'd1);
    check("post_rst_ready1", 32'(req_ready[1]), 32'd1);

    run(0, 1'b1, 2'd2, 32'h40, 32'h0000_1234, 0, rd, er);
    run(0, 1'b0, 2'd2, 32'h40, 32'h0, 0, rd, er);
    check("rd_0x40", rd, 32'h0000_1234);
    run(0, 1'b1, 2'd2, 32'h44, 32'hAABB_CCDD, 0, rd, er);
    run(0, 1'b1, 2'd0, 32'h46, 32'h00EE_0000, 0, rd, er);
    run(0, 1'b0, 2'd2, 32'h44, 32'h0, 0, rd, er);
    check("rd_0x44_merged", rd, 32'hAAEE_CCDD);
    run(0, 1'b1, 2'd2, 32'h42, 32'hFFFF_FFFF, 0, rd, er);
    check("misaligned_err", 32'(er), 32'd1);
    run(0, 1'b0, 2'd2, 32'h40, 32'h0, 0, rd, er);
    check("rd_0x40_unchanged", rd, 32'h0000_1234);
    run(0, 1'b0, 2'd2, 32'h1000, 32'h0, 0, rd, er);
    check("range_err", 32'(er), 32'd2);
    check("range_rdata", rd, 32'h0);

    run(1, 1'b1, 2'd2, 32'h80, 32'h1122_3344, 0, rd, er);
    run(1, 1'b0, 2'd2, 32'h80, 32'h0, 5, rd, er);
    check("ws3_rd_0x80", rd, 32'h1122_3344);

    // Write accepted on the WAIT_STATES=3 instance, then reset while it waits.
    model_apply(1, 1'b1, 2'd2, 32'h84, 32'hCAFE_F00D, erd, eer);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h84; req_wdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("in_wait_ready", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_wait_valid", 32'(resp_valid[1]), 32'd0);
    check("rst_wait_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read on the zero-wait instance, then reset mid-cycle while the response is presented.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'd2; req_addr[0] = 32'h40;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("resp_before_rst", 32'(resp_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_drop_valid", 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready0", 32'(req_ready[0]), 32'd1);
    check("rel_ready1", 32'(req_ready[1]), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) n++;
    end
    check("stale_resp_cycles", 32'(n), 32'd0);

    run(1, 1'b0, 2'd2, 32'h84, 32'h0, 0, rd, er);
    check("write_survives_rst", rd, 32'hCAFE_F00D);

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++)
        run(k, 1'b1, 2'd2, 32'(w * 4), $urandom, 0, rd, er);

    for (int t = 0; t < 300; t++) begin
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 9));
      if (n < 8)       a = 32'($urandom_range(0, 255));
      else if (n == 8) a = 32'h1000 + 32'($urandom_range(0, 300));
      else             a = $urandom;
      run(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
          int'($urandom_range(0, 2)), rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
